progressive_counter: RTL and testbench

- Parameterised N-bit up (progressive) counter; the counting-up counterpart of the team's regressive counter.
- Advances by one on each rising edge of a raw push-button style `increment` input.
- Supports parallel load of a start value, wrap or saturate at the maximum, terminal-count flags, and an active-low hex seven-segment drive of the count.
- Sits between board buttons/switches and the display in the lab top levels.

---
 rtl/progressive_counter.sv | 88 ++++++++
 tb/tb_progressive_counter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/progressive_counter.sv
// N-bit up counter stepped by rising edges of a raw push-button input.
// Supports parallel load, wrap or saturate at max, and an active-low hex seven-segment drive.
module progressive_counter #(
  parameter int unsigned N    = 2,
  parameter bit          WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         increment,
  output logic [N-1:0] count,
  output logic         at_max,
  output logic         wrap_pulse,
  output logic [6:0]   seg
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  logic       inc_s1;
  logic       inc_s2;
  logic       inc_d;
  logic       step;
  logic [3:0] nibble;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_s1 <= 1'b0;
      inc_s2 <= 1'b0;
      inc_d  <= 1'b0;
    end else begin
      inc_s1 <= increment;
      inc_s2 <= inc_s1;
      inc_d  <= inc_s2;
    end
  end

  assign step = inc_s2 & ~inc_d;

  // Load beats step; a step that coincides with a load is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (load) begin
        count <= load_value;
      end else if (step) begin
        if (count != CNT_MAX) begin
          count <= count + N'(1);
        end else if (WRAP) begin
          count      <= '0;
          wrap_pulse <= 1'b1;
        end
      end
    end
  end

  assign at_max = (count == CNT_MAX);

  // Low hex digit; narrower counters are zero-extended
  assign nibble = 4'(count);

  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: tb/tb_progressive_counter.sv
// Bench for progressive_counter: three instances (N=2 wrap, N=2 saturate, N=4 wrap)
// checked every cycle against a history-based behavioural model plus directed literals.
module tb_progressive_counter;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inc [NI];
  logic        ld  [NI];
  logic [15:0] lv  [NI];

  logic [1:0] cnt_a, cnt_s;
  logic [3:0] cnt_b;
  logic       am_a, am_s, am_b;
  logic       wp_a, wp_s, wp_b;
  logic [6:0] seg_a, seg_s, seg_b;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: count, pulse, and the last three increment samples (index 0 newest)
  int mmax  [NI] = '{3, 3, 15};
  bit mwrap [NI] = '{1'b1, 1'b0, 1'b1};
  int m_count [NI];
  bit m_wp    [NI];
  bit hist    [NI][3];
  int wp_hits [NI];
  bit stp;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  progressive_counter #(.N(2), .WRAP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load(ld[0]), .load_value(lv[0][1:0]),
    .increment(inc[0]), .count(cnt_a), .at_max(am_a), .wrap_pulse(wp_a), .seg(seg_a));

  progressive_counter #(.N(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .load(ld[1]), .load_value(lv[1][1:0]),
    .increment(inc[1]), .count(cnt_s), .at_max(am_s), .wrap_pulse(wp_s), .seg(seg_s));

  progressive_counter #(.N(4), .WRAP(1'b1)) dut_b (
    .clk(clk), .reset(reset), .load(ld[2]), .load_value(lv[2][3:0]),
    .increment(inc[2]), .count(cnt_b), .at_max(am_b), .wrap_pulse(wp_b), .seg(seg_b));

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A step lands at edge e when increment was sampled high at e-2 and low at e-3
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_count[i] = 0;
        m_wp[i]    = 1'b0;
        hist[i][0] = 1'b0;
        hist[i][1] = 1'b0;
        hist[i][2] = 1'b0;
      end else begin
        stp     = hist[i][1] && !hist[i][2];
        m_wp[i] = 1'b0;
        if (ld[i]) begin
          m_count[i] = int'(lv[i]) % (mmax[i] + 1);
        end else if (stp) begin
          if (m_count[i] < mmax[i]) m_count[i] = m_count[i] + 1;
          else if (mwrap[i]) begin
            m_count[i] = 0;
            m_wp[i]    = 1'b1;
          end
        end
        hist[i][2] = hist[i][1];
        hist[i][1] = hist[i][0];
        hist[i][0] = inc[i];
      end
    end
  end

  task automatic chk_inst(string tag, int i, int c, int am, int wp, int sg);
    chk({tag, "_count"}, c, m_count[i]);
    chk({tag, "_at_max"}, am, (m_count[i] == mmax[i]) ? 1 : 0);
    chk({tag, "_wrap_pulse"}, wp, int'(m_wp[i]));
    chk({tag, "_seg"}, sg, int'(seg_tab[m_count[i] % 16]));
    if (wp != 0) wp_hits[i]++;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk_inst("a", 0, int'(cnt_a), int'(am_a), int'(wp_a), int'(seg_a));
      chk_inst("s", 1, int'(cnt_s), int'(am_s), int'(wp_s), int'(seg_s));
      chk_inst("b", 2, int'(cnt_b), int'(am_b), int'(wp_b), int'(seg_b));
    end
  end

  task automatic pulse(int i, int len);
    @(negedge clk);
    inc[i] = 1'b1;
    repeat (len) @(negedge clk);
    inc[i] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  int wp_before;

  initial begin
    for (int i = 0; i < NI; i++) begin
      inc[i] = 1'b0;
      ld[i]  = 1'b0;
      lv[i]  = 16'h0;
      m_count[i] = 0;
      m_wp[i] = 1'b0;
      wp_hits[i] = 0;
      for (int j = 0; j < 3; j++) hist[i][j] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_count_a", int'(cnt_a), 0);
    chk("rst_at_max_a", int'(am_a), 0);
    chk("rst_wrap_a", int'(wp_a), 0);
    chk("rst_seg_a", int'(seg_a), int'(7'b1000000));
    chk("rst_seg_b", int'(seg_b), int'(7'b1000000));

    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_count_a", int'(cnt_a), 0);

    // Latency: first sampling edge k, count changes at edge k+2
    inc[0] = 1'b1;
    @(posedge clk); #1 chk("lat_edge1", int'(cnt_a), 0);
    @(posedge clk); #1 chk("lat_edge2", int'(cnt_a), 0);
    @(posedge clk); #1 chk("lat_edge3", int'(cnt_a), 1);
    chk("cnt1_at_max", int'(am_a), 0);
    repeat (97) @(negedge clk);
    inc[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_one_step", int'(cnt_a), 1);
    pulse(0, 100);
    chk("cnt2", int'(cnt_a), 2);
    pulse(0, 100);
    chk("cnt3", int'(cnt_a), 3);
    chk("cnt3_at_max", int'(am_a), 1);
    chk("cnt3_seg", int'(seg_a), int'(7'b0110000));

    // Wrap
    wp_before = wp_hits[0];
    pulse(0, 10);
    chk("wrap_count", int'(cnt_a), 0);
    chk("wrap_pulse_cycles", wp_hits[0] - wp_before, 1);
    chk("wrap_at_max", int'(am_a), 0);

    // Saturate
    repeat (3) pulse(1, 5);
    chk("sat_fill", int'(cnt_s), 3);
    pulse(1, 5);
    pulse(1, 5);
    chk("sat_count", int'(cnt_s), 3);
    chk("sat_at_max", int'(am_s), 1);
    chk("sat_no_wrap", wp_hits[1], 0);

    // Load coinciding with a step: step is lost
    @(negedge clk) inc[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ld[2] = 1'b1;
    lv[2] = 16'hA;
    @(negedge clk) ld[2] = 1'b0;
    chk("load_count", int'(cnt_b), 10);
    chk("load_seg", int'(seg_b), int'(7'b0001000));
    repeat (5) @(negedge clk);
    chk("load_step_lost", int'(cnt_b), 10);
    inc[2] = 1'b0;
    repeat (4) @(negedge clk);
    pulse(2, 5);
    chk("after_load_step", int'(cnt_b), 11);

    // Reset mid-operation with increment held through release
    @(negedge clk) inc[2] = 1'b1;
    repeat (5) @(negedge clk);
    ld[2] = 1'b1;
    lv[2] = 16'h5;
    @(negedge clk) ld[2] = 1'b0;
    chk("pre_rst_count", int'(cnt_b), 5);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_count", int'(cnt_b), 0);
    chk("mid_rst_seg", int'(seg_b), int'(7'b1000000));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rel_one_step", int'(cnt_b), 1);
    repeat (10) @(negedge clk);
    chk("rel_no_more", int'(cnt_b), 1);
    inc[2] = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
